// File: rtl/wallace_pipe.sv
// Pipelined WIDTHxWIDTH multiplier built from 2x2 tiles merged level by level,
// with an elastic valid/ready pipeline and runtime signed/unsigned mode.
module wallace_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_TYPE = 0,
  parameter int PIPE_STAGES = 1,
  parameter int SIGNED_EN   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_signed,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_ab
);

  localparam int HALF = WIDTH / 2;
  localparam int NT   = HALF * HALF;
  localparam int NL   = $clog2(WIDTH) - 1;

  typedef logic [2*WIDTH-1:0] word_t;
  localparam word_t ONE_W = word_t'(1'b1);

  function automatic logic [3:0] mul_2x2(input logic [1:0] a, input logic [1:0] b,
                                         input logic approx);
    if (approx && (a == 2'b11) && (b == 2'b11)) return 4'b0111;
    else return {2'b00, a} * {2'b00, b};
  endfunction

  function automatic logic tile_approx(input int i, input int j);
    if (APPROX_TYPE == 2) return 1'b1;
    else if (APPROX_TYPE == 1) return (2 * (i + j)) < WIDTH;
    else return 1'b0;
  endfunction

  // Low quadrant LSBs pass straight through; everything above is one carry sum.
  function automatic word_t merge4(input word_t ll, input word_t lh, input word_t hl,
                                   input word_t hh, input int cp);
    word_t mask;
    word_t hi;
    mask = (ONE_W << cp) - ONE_W;
    hi   = (ll >> cp) + lh + hl + (hh << cp);
    return (ll & mask) | (hi << cp);
  endfunction

  logic             sgn_s, neg_s, accept_s, out_en_s, chain_s, v_s, n_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [NL:0]      en_s, lv_d, lv_q, ln_d, ln_q;
  word_t            tiles_s [NT];
  word_t            src_s   [NT];
  word_t            cur_s   [NT];
  word_t            lay_d   [NL+1][NT];
  word_t            lay_q   [NL+1][NT];
  logic             o_valid_d, o_valid_q;
  word_t            o_ab_d, o_ab_q;

  // Operand magnitudes and result sign.
  always_comb begin
    sgn_s   = (SIGNED_EN != 0) ? i_signed : 1'b0;
    mag_a_s = (sgn_s && i_a[WIDTH-1]) ? (~i_a + {{(WIDTH-1){1'b0}}, 1'b1}) : i_a;
    mag_b_s = (sgn_s && i_b[WIDTH-1]) ? (~i_b + {{(WIDTH-1){1'b0}}, 1'b1}) : i_b;
    neg_s   = sgn_s & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
  end

  // Capture enables ripple back from the output register.
  always_comb begin
    out_en_s = !o_valid_q | i_ready;
    chain_s  = out_en_s;
    en_s     = '0;
    for (int l = NL; l >= 0; l--) begin
      if (l < PIPE_STAGES) begin
        en_s[l] = !lv_q[l] | chain_s;
        chain_s = en_s[l];
      end else begin
        en_s[l] = 1'b0;
      end
    end
    o_ready  = !i_rst & chain_s;
    accept_s = i_valid & o_ready;
  end

  // Tile products, merge levels and optional per-layer registers.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      tiles_s[t] = '0;
      src_s[t]   = '0;
      cur_s[t]   = '0;
    end
    for (int i = 0; i < HALF; i++) begin
      for (int j = 0; j < HALF; j++) begin
        tiles_s[i*HALF+j] = word_t'(mul_2x2(mag_a_s[2*i +: 2], mag_b_s[2*j +: 2],
                                            tile_approx(i, j)));
      end
    end
    v_s = accept_s;
    n_s = neg_s;
    for (int l = 0; l <= NL; l++) begin
      if (l == 0) begin
        for (int t = 0; t < NT; t++) cur_s[t] = tiles_s[t];
      end else begin
        for (int i = 0; i < (WIDTH >> (l + 1)); i++) begin
          for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
            cur_s[i*(WIDTH >> (l + 1))+j] = merge4(
              src_s[(2*i)*(WIDTH >> l) + 2*j],
              src_s[(2*i)*(WIDTH >> l) + 2*j + 1],
              src_s[(2*i+1)*(WIDTH >> l) + 2*j],
              src_s[(2*i+1)*(WIDTH >> l) + 2*j + 1],
              1 << l);
          end
        end
      end
      for (int t = 0; t < NT; t++) lay_d[l][t] = (en_s[l] & v_s) ? cur_s[t] : lay_q[l][t];
      lv_d[l] = en_s[l] ? v_s : lv_q[l];
      ln_d[l] = (en_s[l] & v_s) ? n_s : ln_q[l];
      if (l < PIPE_STAGES) begin
        for (int t = 0; t < NT; t++) src_s[t] = lay_q[l][t];
        v_s = lv_q[l];
        n_s = ln_q[l];
      end else begin
        for (int t = 0; t < NT; t++) src_s[t] = cur_s[t];
      end
    end
    o_valid_d = out_en_s ? v_s : o_valid_q;
    o_ab_d    = (out_en_s & v_s) ? (n_s ? (~src_s[0] + ONE_W) : src_s[0]) : o_ab_q;
  end

  // Pipeline and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lv_q      <= '0;
      ln_q      <= '0;
      o_valid_q <= 1'b0;
      o_ab_q    <= '0;
      for (int l = 0; l <= NL; l++)
        for (int t = 0; t < NT; t++) lay_q[l][t] <= '0;
    end else begin
      lv_q      <= lv_d;
      ln_q      <= ln_d;
      o_valid_q <= o_valid_d;
      o_ab_q    <= o_ab_d;
      for (int l = 0; l <= NL; l++)
        for (int t = 0; t < NT; t++) lay_q[l][t] <= lay_d[l][t];
    end
  end

  assign o_valid = o_valid_q;
  assign o_ab    = o_ab_q;

endmodule

// File: tb/tb_wallace_pipe.sv
// Self-checking bench for wallace_pipe: four configurations against an arithmetic reference model.
module tb_wallace_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A: W=8, exact, PIPE_STAGES=1
  logic a_valid, a_ready, a_sgn, a_ovalid, a_iready, a_bp;
  logic [7:0]  a_a, a_b;
  logic [15:0] a_ab;
  wallace_pipe #(.WIDTH(8), .APPROX_TYPE(0), .PIPE_STAGES(1), .SIGNED_EN(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_a(a_a), .i_b(a_b),
    .i_signed(a_sgn), .o_valid(a_ovalid), .i_ready(a_iready), .o_ab(a_ab));

  // B: W=4, APPROX_TYPE=1, PIPE_STAGES=0;  D: W=4, APPROX_TYPE=2, PIPE_STAGES=1, unsigned only
  logic q_valid, q_sgn, b_ready, b_ovalid, d_ready, d_ovalid;
  logic [3:0] q_a, q_b;
  logic [7:0] b_ab, d_ab;
  wallace_pipe #(.WIDTH(4), .APPROX_TYPE(1), .PIPE_STAGES(0), .SIGNED_EN(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(q_valid), .o_ready(b_ready), .i_a(q_a), .i_b(q_b),
    .i_signed(q_sgn), .o_valid(b_ovalid), .i_ready(1'b1), .o_ab(b_ab));
  wallace_pipe #(.WIDTH(4), .APPROX_TYPE(2), .PIPE_STAGES(1), .SIGNED_EN(0)) u_d (
    .i_clk(clk), .i_rst(rst), .i_valid(q_valid), .o_ready(d_ready), .i_a(q_a), .i_b(q_b),
    .i_signed(q_sgn), .o_valid(d_ovalid), .i_ready(1'b1), .o_ab(d_ab));

  // C: W=16, exact, PIPE_STAGES=3
  logic c_valid, c_ready, c_sgn, c_ovalid, c_iready;
  logic [15:0] c_a, c_b;
  logic [31:0] c_ab;
  wallace_pipe #(.WIDTH(16), .APPROX_TYPE(0), .PIPE_STAGES(3), .SIGNED_EN(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .o_ready(c_ready), .i_a(c_a), .i_b(c_b),
    .i_signed(c_sgn), .o_valid(c_ovalid), .i_ready(c_iready), .o_ab(c_ab));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product of magnitudes, minus 2 at each approximate tile whose digits are both 3.
  function automatic longint ref_mul(input int w, input int ap, input longint a,
                                     input longint b, input bit s);
    longint sa, sb, ma, mb, p;
    bit neg;
    sa  = (s && ((a >> (w - 1)) & 64'sd1) != 64'sd0) ? a - (64'sd1 << w) : a;
    sb  = (s && ((b >> (w - 1)) & 64'sd1) != 64'sd0) ? b - (64'sd1 << w) : b;
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    p   = ma * mb;
    for (int i = 0; i < w / 2; i++)
      for (int j = 0; j < w / 2; j++)
        if (((ap == 2) || (ap == 1 && 2 * (i + j) < w)) &&
            ((ma >> (2 * i)) & 64'sd3) == 64'sd3 && ((mb >> (2 * j)) & 64'sd3) == 64'sd3)
          p = p - (64'sd2 << (2 * (i + j)));
    if (neg) p = -p;
    return p & ((64'sd1 << (2 * w)) - 64'sd1);
  endfunction

  longint a_q[$], b_q[$], d_q[$], c_q[$];
  bit     a_stall_prev = 1'b0, c_stall_prev = 1'b0;
  logic [15:0] a_ab_prev;
  logic [31:0] c_ab_prev;
  bit     c_track = 1'b0, c_seen = 1'b0;
  int     c_gaps = 0, c_first_v = -1, c_acc = 0;
  longint e;

  // Scoreboards: push on accept, pop and compare on delivery, check holds during stalls.
  always @(negedge clk) begin
    if (rst) begin
      a_q.delete(); b_q.delete(); d_q.delete(); c_q.delete();
      a_stall_prev = 1'b0;
      c_stall_prev = 1'b0;
    end else begin
      if (a_stall_prev) begin
        chk("a_stall_valid", a_ovalid, 1'b1);
        chk("a_stall_hold", a_ab, a_ab_prev);
      end
      if (c_stall_prev) begin
        chk("c_stall_valid", c_ovalid, 1'b1);
        chk("c_stall_hold", c_ab, c_ab_prev);
      end
      if (c_track) begin
        if (c_ovalid && !c_seen) begin
          c_seen    = 1'b1;
          c_first_v = cyc;
        end else if (c_seen && !c_ovalid && c_q.size() != 0) begin
          c_gaps++;
        end
      end
      if (a_valid && a_ready) a_q.push_back(ref_mul(8, 0, a_a, a_b, a_sgn));
      if (c_valid && c_ready) c_q.push_back(ref_mul(16, 0, c_a, c_b, c_sgn));
      if (q_valid && b_ready) begin
        b_q.push_back(ref_mul(4, 1, q_a, q_b, q_sgn));
        d_q.push_back(ref_mul(4, 2, q_a, q_b, 1'b0));
        chk("d_ready", d_ready, 1'b1);
      end
      if (a_ovalid && a_iready) begin
        chk("a_expected_pending", 64'(a_q.size() != 0), 1'b1);
        if (a_q.size() != 0) begin e = a_q.pop_front(); chk("a_product", a_ab, e); end
      end
      if (c_ovalid && c_iready) begin
        chk("c_expected_pending", 64'(c_q.size() != 0), 1'b1);
        if (c_q.size() != 0) begin e = c_q.pop_front(); chk("c_product", c_ab, e); end
      end
      if (b_ovalid) begin
        chk("b_expected_pending", 64'(b_q.size() != 0), 1'b1);
        if (b_q.size() != 0) begin e = b_q.pop_front(); chk("b_product", b_ab, e); end
      end
      if (d_ovalid) begin
        chk("d_expected_pending", 64'(d_q.size() != 0), 1'b1);
        if (d_q.size() != 0) begin e = d_q.pop_front(); chk("d_product", d_ab, e); end
      end
      a_stall_prev = a_ovalid && !a_iready;
      a_ab_prev    = a_ab;
      c_stall_prev = c_ovalid && !c_iready;
      c_ab_prev    = c_ab;
    end
  end

  task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic s);
    bit ok = 1'b0;
    a_valid = 1'b1; a_a = a; a_b = b; a_sgn = s;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = a_ready;
      @(posedge clk); #1;
      if (a_bp) a_iready = 1'($urandom_range(0, 1));
    end
    a_valid = 1'b0;
    chk("a_accept", ok, 1'b1);
  endtask

  task automatic send_q(input logic [3:0] a, input logic [3:0] b, input logic s);
    bit ok = 1'b0;
    q_valid = 1'b1; q_a = a; q_b = b; q_sgn = s;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = b_ready;
      @(posedge clk); #1;
    end
    q_valid = 1'b0;
    chk("q_accept", ok, 1'b1);
  endtask

  task automatic send_c(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit ok = 1'b0;
    c_valid = 1'b1; c_a = a; c_b = b; c_sgn = s;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = c_ready;
      if (ok) c_acc = cyc;
      @(posedge clk); #1;
    end
    c_valid = 1'b0;
    chk("c_accept", ok, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, first_acc, quiet;
    rst = 1'b1; a_bp = 1'b0;
    a_valid = 1'b1; a_a = 8'd5; a_b = 8'd7; a_sgn = 1'b0; a_iready = 1'b1;
    q_valid = 1'b0; q_a = 4'd0; q_b = 4'd0; q_sgn = 1'b0;
    c_valid = 1'b0; c_a = 16'd0; c_b = 16'd0; c_sgn = 1'b0; c_iready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_a_valid", a_ovalid, 1'b0);
    chk("rst_a_ab", a_ab, 16'h0000);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_c_ready", c_ready, 1'b0);
    chk("rst_c_ab", c_ab, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wins_no_output", a_ovalid, 1'b0);
    chk("a_ready_idle", a_ready, 1'b1);

    // 255*255 appears exactly two cycles after accept
    @(posedge clk); #1;
    a_valid = 1'b1; a_a = 8'hFF; a_b = 8'hFF; a_sgn = 1'b0;
    @(negedge clk); chk("a_lat_accept", a_ready, 1'b1);
    @(posedge clk); #1; a_valid = 1'b0;
    @(negedge clk); chk("a_lat_not_yet", a_ovalid, 1'b0);
    @(negedge clk); chk("a_lat_valid", a_ovalid, 1'b1); chk("a_lat_ab", a_ab, 16'hFE01);
    @(posedge clk); #1;

    send_a(8'h80, 8'h80, 1'b1);
    send_a(8'hFF, 8'h7F, 1'b1);
    send_a(8'h80, 8'h7F, 1'b1);
    send_a(8'h80, 8'h80, 1'b0);
    send_a(8'hFF, 8'hFF, 1'b1);
    a_bp = 1'b1;
    for (int n = 0; n < 3000; n++) send_a(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    a_bp = 1'b0; a_iready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("a_drained", a_q.size(), 0);

    send_q(4'd12, 4'd12, 1'b0);
    send_q(4'd3, 4'd3, 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) send_q(4'(a), 4'(b), 1'($urandom_range(0, 1)));
    repeat (5) @(posedge clk); #1;
    chk("b_drained", b_q.size(), 0);
    chk("d_drained", d_q.size(), 0);

    // Backpressure from an empty pipe: four stages fill, then o_ready drops
    c_iready = 1'b0; c_valid = 1'b1; n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      c_a = 16'($urandom); c_b = 16'($urandom); c_sgn = 1'($urandom_range(0, 1));
      @(negedge clk); if (c_ready) n_acc++;
      @(posedge clk); #1;
    end
    c_valid = 1'b0;
    chk("c_bp_accepts", n_acc, 4);
    @(negedge clk); chk("c_bp_ready_low", c_ready, 1'b0);
    @(posedge clk); #1; c_iready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("c_bp_drained", c_q.size(), 0);

    c_track = 1'b1;
    first_acc = 0;
    for (int n = 0; n < 100; n++) begin
      send_c(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      if (n == 0) first_acc = c_acc;
    end
    for (int k = 0; k < 20 && c_q.size() != 0; k++) @(posedge clk);
    #1;
    c_track = 1'b0;
    chk("c_stream_drained", c_q.size(), 0);
    chk("c_stream_gaps", c_gaps, 0);
    chk("c_stream_latency", c_first_v - first_acc, 4);

    // Reset with three items in flight
    send_c(16'h1234, 16'h5678, 1'b0);
    send_c(16'hFFFF, 16'h0002, 1'b1);
    send_c(16'h8000, 16'h8000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("c_rst_valid", c_ovalid, 1'b0);
    chk("c_rst_ab", c_ab, 32'h0);
    quiet = 0;
    repeat (6) begin @(negedge clk); if (c_ovalid) quiet++; end
    chk("c_rst_no_stale", quiet, 0);
    @(posedge clk); #1;
    send_c(16'h00FF, 16'h0101, 1'b0);
    first_acc = c_acc;
    for (int k = 0; k < 20 && !c_ovalid; k++) @(negedge clk);
    chk("c_post_rst_latency", cyc - first_acc, 4);
    repeat (5) @(posedge clk); #1;
    chk("c_final_drained", c_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
